// File: rtl/exe_pkg.sv
// Shared types for the execute stage: ALU commands, multiplier states,
// the EXE/MEM bundle and the operand forwarding rule.
package exe_pkg;

    typedef enum logic [3:0] {
        CMD_ADD = 4'd0,
        CMD_SUB = 4'd1,
        CMD_AND = 4'd2,
        CMD_OR  = 4'd3,
        CMD_NOR = 4'd4,
        CMD_XOR = 4'd5,
        CMD_SLL = 4'd6,
        CMD_SRA = 4'd7,
        CMD_SRL = 4'd8,
        CMD_MUL = 4'd9
    } exe_cmd_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mul_state_e;

    typedef struct packed {
        logic        wb_en;
        logic [1:0]  mem_sig;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] reg2;
    } exe_mem_t;

    localparam exe_mem_t BUBBLE = '0;

    // MEM wins over WB; register 0 is never forwarded
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  src,
        input logic        mem_wb_en,
        input logic [4:0]  mem_dest,
        input logic [31:0] mem_val,
        input logic        wb_wb_en,
        input logic [4:0]  wb_dest,
        input logic [31:0] wb_val,
        input logic [31:0] id_val
    );
        logic [31:0] r;
        r = id_val;
        if (src != 5'd0) begin
            if (mem_wb_en && mem_dest == src)
                r = mem_val;
            else if (wb_wb_en && wb_dest == src)
                r = wb_val;
        end
        return r;
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EX inputs, forwarding sources and EXE/MEM outputs of the execute stage.
interface exe_stage_if;
    logic        flush;
    logic        wb_en_in;
    logic [1:0]  mem_sig_in;
    logic [4:0]  dest_in;
    logic [3:0]  exe_cmd_in;
    logic [4:0]  src1_in;
    logic [4:0]  src2_in;
    logic [31:0] val1_in;
    logic [31:0] reg2_in;
    logic        imm_in;
    logic [31:0] val2_in;
    logic        mem_wb_en;
    logic        wb_wb_en;
    logic [4:0]  mem_dest;
    logic [4:0]  wb_dest;
    logic [31:0] mem_fwd_val;
    logic [31:0] wb_fwd_val;
    logic        exe_busy;
    logic        wb_en_out;
    logic [1:0]  mem_sig_out;
    logic [4:0]  dest_out;
    logic [31:0] alu_result_out;
    logic [31:0] reg2_out;

    modport master (
        output flush, wb_en_in, mem_sig_in, dest_in, exe_cmd_in,
        output src1_in, src2_in, val1_in, reg2_in, imm_in, val2_in,
        output mem_wb_en, wb_wb_en, mem_dest, wb_dest,
        output mem_fwd_val, wb_fwd_val,
        input  exe_busy, wb_en_out, mem_sig_out, dest_out,
        input  alu_result_out, reg2_out
    );

    modport slave (
        input  flush, wb_en_in, mem_sig_in, dest_in, exe_cmd_in,
        input  src1_in, src2_in, val1_in, reg2_in, imm_in, val2_in,
        input  mem_wb_en, wb_wb_en, mem_dest, wb_dest,
        input  mem_fwd_val, wb_fwd_val,
        output exe_busy, wb_en_out, mem_sig_out, dest_out,
        output alu_result_out, reg2_out
    );
endinterface

// File: rtl/exe_stage_seq_multiplier.sv
// Iterative 32-step shift-add multiplier, low 32 bits of the product.
module seq_multiplier
    import exe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] product_o
);
    mul_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] sum;

    // Last step folds into the output so the product is ready at count 31
    assign sum       = acc_q + (b_q[0] ? a_q : 32'd0);
    assign product_o = sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    busy_o = 1'b1;
                    if (!abort_i) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        a_d     = a_i;
                        b_d     = b_i;
                        acc_d   = '0;
                    end
                end
            end
            RUN: begin
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                acc_d = sum;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    done_o  = 1'b1;
                    state_d = IDLE;
                end else begin
                    busy_o = 1'b1;
                end
                if (abort_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, ALU, iterative MUL and the EXE/MEM
// pipeline register.
module exe_stage
    import exe_pkg::*;
(
    input logic         clk,
    input logic         rst,
    exe_stage_if.slave  bus
);
    logic [31:0] op1, op2, reg2_fwd, alu_res, product;
    logic [4:0]  shamt;
    logic        mul_busy, mul_done, is_mul;
    exe_mem_t    exe_mem_q, exe_mem_d;

    assign op1 = fwd_sel(bus.src1_in, bus.mem_wb_en, bus.mem_dest,
                         bus.mem_fwd_val, bus.wb_wb_en, bus.wb_dest,
                         bus.wb_fwd_val, bus.val1_in);
    assign reg2_fwd = fwd_sel(bus.src2_in, bus.mem_wb_en, bus.mem_dest,
                              bus.mem_fwd_val, bus.wb_wb_en, bus.wb_dest,
                              bus.wb_fwd_val, bus.reg2_in);
    assign op2 = bus.imm_in ? bus.val2_in :
                 fwd_sel(bus.src2_in, bus.mem_wb_en, bus.mem_dest,
                         bus.mem_fwd_val, bus.wb_wb_en, bus.wb_dest,
                         bus.wb_fwd_val, bus.val2_in);
    assign shamt  = op2[4:0];
    assign is_mul = (bus.exe_cmd_in == CMD_MUL);

    seq_multiplier u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (is_mul),
        .abort_i   (bus.flush),
        .a_i       (op1),
        .b_i       (op2),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (product)
    );

    assign bus.exe_busy = mul_busy & ~bus.flush & ~rst;

    always_comb begin
        alu_res = '0;
        unique case (bus.exe_cmd_in)
            CMD_ADD: alu_res = op1 + op2;
            CMD_SUB: alu_res = op1 - op2;
            CMD_AND: alu_res = op1 & op2;
            CMD_OR:  alu_res = op1 | op2;
            CMD_NOR: alu_res = ~(op1 | op2);
            CMD_XOR: alu_res = op1 ^ op2;
            CMD_SLL: alu_res = op1 << shamt;
            CMD_SRA: alu_res = $signed(op1) >>> shamt;
            CMD_SRL: alu_res = op1 >> shamt;
            CMD_MUL: alu_res = mul_done ? product : 32'd0;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        exe_mem_d = BUBBLE;
        if (!bus.flush && !bus.exe_busy) begin
            exe_mem_d.wb_en      = bus.wb_en_in;
            exe_mem_d.mem_sig    = bus.mem_sig_in;
            exe_mem_d.dest       = bus.dest_in;
            exe_mem_d.alu_result = alu_res;
            exe_mem_d.reg2       = reg2_fwd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) exe_mem_q <= BUBBLE;
        else     exe_mem_q <= exe_mem_d;
    end

    assign bus.wb_en_out      = exe_mem_q.wb_en;
    assign bus.mem_sig_out    = exe_mem_q.mem_sig;
    assign bus.dest_out       = exe_mem_q.dest;
    assign bus.alu_result_out = exe_mem_q.alu_result;
    assign bus.reg2_out       = exe_mem_q.reg2;
endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: reference model pushes expected EXE/MEM
// bundles, the output side pops and compares them.
module tb_exe_stage;
    import exe_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exe_stage_if bus ();

    exe_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int       n_pass  = 0;
    int       n_total = 0;
    exe_mem_t expq[$];

    task automatic check(string tag, logic [71:0] got, logic [71:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] fw(logic [4:0] s, logic [31:0] v);
        if (s != 0 && bus.mem_wb_en && bus.mem_dest == s) return bus.mem_fwd_val;
        if (s != 0 && bus.wb_wb_en && bus.wb_dest == s) return bus.wb_fwd_val;
        return v;
    endfunction

    function automatic exe_mem_t model();
        exe_mem_t    e;
        logic [31:0] a, b, r;
        a = fw(bus.src1_in, bus.val1_in);
        b = bus.imm_in ? bus.val2_in : fw(bus.src2_in, bus.val2_in);
        case (bus.exe_cmd_in)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = ~(a | b);
            4'd5: r = a ^ b;
            4'd6: r = a << b[4:0];
            4'd7: r = $signed(a) >>> b[4:0];
            4'd8: r = a >> b[4:0];
            4'd9: r = a * b;
            default: r = 32'd0;
        endcase
        e.wb_en      = bus.wb_en_in;
        e.mem_sig    = bus.mem_sig_in;
        e.dest       = bus.dest_in;
        e.alu_result = r;
        e.reg2       = fw(bus.src2_in, bus.reg2_in);
        return e;
    endfunction

    function automatic exe_mem_t observed();
        exe_mem_t o;
        o.wb_en      = bus.wb_en_out;
        o.mem_sig    = bus.mem_sig_out;
        o.dest       = bus.dest_out;
        o.alu_result = bus.alu_result_out;
        o.reg2       = bus.reg2_out;
        return o;
    endfunction

    task automatic issue(logic [3:0] cmd, logic [4:0] s1, logic [31:0] v1,
                         logic [4:0] s2, logic [31:0] r2, logic imm,
                         logic [31:0] v2, logic [1:0] ms, logic [4:0] d);
        bus.exe_cmd_in = cmd;
        bus.src1_in    = s1;
        bus.val1_in    = v1;
        bus.src2_in    = s2;
        bus.reg2_in    = r2;
        bus.imm_in     = imm;
        bus.val2_in    = v2;
        bus.mem_sig_in = ms;
        bus.dest_in    = d;
        bus.wb_en_in   = 1'b1;
    endtask

    task automatic fwd(logic mwe, logic [4:0] md, logic [31:0] mv,
                       logic wwe, logic [4:0] wd, logic [31:0] wv);
        bus.mem_wb_en   = mwe;
        bus.mem_dest    = md;
        bus.mem_fwd_val = mv;
        bus.wb_wb_en    = wwe;
        bus.wb_dest     = wd;
        bus.wb_fwd_val  = wv;
    endtask

    task automatic pop_check(string tag);
        if (expq.size() == 0) begin
            check({tag, "_empty"}, 1'b1, 1'b0);
        end else begin
            check(tag, observed(), expq.pop_front());
        end
    endtask

    task automatic run1(string tag);
        expq.push_back(model());
        tick();
        pop_check(tag);
    endtask

    task automatic run_mul(string tag, logic [31:0] want, logic poke);
        int   n;
        logic ok;
        expq.push_back(model());
        #1;
        check({tag, "_busy_t"}, bus.exe_busy, 1'b1);
        n  = 0;
        ok = 1'b1;
        while (bus.exe_busy && n < 64) begin
            tick();
            n++;
            if (observed() != BUBBLE) ok = 1'b0;
            if (poke) bus.mem_fwd_val = $urandom;
        end
        check({tag, "_bubbles"}, ok, 1'b1);
        check({tag, "_busy_cycles"}, n, 32);
        tick();
        pop_check(tag);
        check({tag, "_const"}, bus.alu_result_out, want);
    endtask

    initial begin
        bus.flush = 1'b0;
        rst = 1'b1;
        fwd(1'b1, 5'd3, 32'd100, 1'b1, 5'd3, 32'd200);
        issue(4'd0, 5'd3, 32'd5, 5'd2, 32'd9, 1'b0, 32'd7, 2'b11, 5'd8);
        tick();
        tick();
        check("reset_out", observed(), BUBBLE);
        check("reset_busy", bus.exe_busy, 1'b0);
        rst = 1'b0;

        fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        issue(4'd0, 5'd1, 32'd5, 5'd2, 32'd0, 1'b0, 32'd7, 2'b00, 5'd1);
        run1("add");
        check("add_const", bus.alu_result_out, 32'd12);

        fwd(1'b1, 5'd3, 32'd100, 1'b1, 5'd3, 32'd200);
        issue(4'd1, 5'd3, 32'd50, 5'd0, 32'd0, 1'b1, 32'd1, 2'b00, 5'd4);
        run1("fwd_mem");
        check("fwd_mem_const", bus.alu_result_out, 32'd99);
        bus.src1_in = 5'd0;
        run1("fwd_r0");
        check("fwd_r0_const", bus.alu_result_out, 32'd49);

        fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'hDEAD);
        issue(4'd0, 5'd0, 32'd0, 5'd4, 32'd11, 1'b1, 32'd1028, 2'b01, 5'd0);
        run1("store");
        check("store_addr", bus.alu_result_out, 32'd1028);
        check("store_data", bus.reg2_out, 32'hDEAD);
        check("store_sig", bus.mem_sig_out, 2'b01);

        fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        issue(4'd9, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'd7, 1'b0, 32'd3, 2'b00, 5'd9);
        run_mul("mul", 32'hFFFF_FFFD, 1'b0);
        check("mul_wb_en", bus.wb_en_out, 1'b1);

        fwd(1'b1, 5'd3, 32'h0001_0003, 1'b0, 5'd0, 32'd0);
        issue(4'd9, 5'd3, 32'd1, 5'd0, 32'd7, 1'b0, 32'h0002_0005, 2'b00, 5'd10);
        run_mul("mul_hold", 32'h000B_0000 + 32'd15, 1'b1);

        fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        issue(4'd9, 5'd1, 32'd6, 5'd2, 32'd0, 1'b0, 32'd7, 2'b00, 5'd5);
        for (int i = 0; i < 11; i++) tick();
        bus.flush = 1'b1;
        #1;
        check("flush_busy", bus.exe_busy, 1'b0);
        tick();
        check("flush_bubble", observed(), BUBBLE);
        bus.flush = 1'b0;
        issue(4'd0, 5'd1, 32'd20, 5'd2, 32'd0, 1'b0, 32'd22, 2'b00, 5'd6);
        #1;
        check("post_flush_busy", bus.exe_busy, 1'b0);
        run1("post_flush_add");
        check("post_flush_const", bus.alu_result_out, 32'd42);

        issue(4'd7, 5'd1, 32'h8000_0000, 5'd0, 32'd0, 1'b1, 32'd4, 2'b00, 5'd7);
        run1("sra");
        check("sra_const", bus.alu_result_out, 32'hF800_0000);
        bus.exe_cmd_in = 4'd8;
        run1("srl");
        check("srl_const", bus.alu_result_out, 32'h0800_0000);
        issue(4'd6, 5'd1, 32'd1, 5'd0, 32'd0, 1'b1, 32'd31, 2'b00, 5'd7);
        run1("sll");
        check("sll_const", bus.alu_result_out, 32'h8000_0000);
        bus.exe_cmd_in = 4'd12;
        run1("cmd12");
        check("cmd12_const", bus.alu_result_out, 32'd0);

        for (int i = 0; i < 16; i++) begin
            logic [3:0] c;
            c = 4'($urandom_range(0, 15));
            if (c == 4'd9) c = 4'd5;
            fwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
                1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            issue(c, 5'($urandom_range(0, 3)), $urandom,
                  5'($urandom_range(0, 3)), $urandom, 1'($urandom),
                  $urandom, 2'($urandom), 5'($urandom));
            bus.wb_en_in = 1'($urandom);
            run1("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
